lcd_pattern_timing: RTL and testbench

LCD_PATTERN_TIMING -- requirements
Module: lcd_pattern_timing

---
 rtl/lcd_pattern_timing.sv | 162 ++++++++++++++++
 tb/tb_lcd_pattern_timing.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_timing.sv
// LCD timing generator with built-in test patterns (colour bars, checkerboard,
// gray ramp, solid). All outputs are registered one cycle after the counter state.
module lcd_pattern_timing #(
  parameter int H_SYNC    = 1,
  parameter int H_BP      = 46,
  parameter int H_DISP    = 800,
  parameter int H_FP      = 210,
  parameter int V_SYNC    = 1,
  parameter int V_BP      = 23,
  parameter int V_DISP    = 480,
  parameter int V_FP      = 22,
  parameter int DATA_W    = 8,
  parameter int NUM_BARS  = 8,
  parameter int CHK_SHIFT = 5,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic                lcd_pclk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [3*DATA_W-1:0] solid_rgb,
  output logic                lcd_de,
  output logic                lcd_hs,
  output logic                lcd_vs,
  output logic [3*DATA_W-1:0] lcd_rgb,
  output logic [10:0]         pixel_xpos,
  output logic [10:0]         pixel_ypos,
  output logic                frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_DISP / NUM_BARS;
  localparam int SW      = (BAR_W > 1) ? $clog2(BAR_W + 1) : 1;
  localparam int IDX_W   = (NUM_BARS > 8) ? $clog2(NUM_BARS) : 3;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_START_C = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_PRE_C   = HW'(H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_END_C   = HW'(H_SYNC + H_BP + H_DISP);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_START_C = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_END_C   = VW'(V_SYNC + V_BP + V_DISP);
  localparam logic [SW-1:0] BAR_LAST  = SW'(BAR_W - 1);

  localparam logic [DATA_W-1:0] FULL = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] NONE = {DATA_W{1'b0}};

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [SW-1:0]         bar_sub;
  logic [IDX_W-1:0]      bar_idx;
  logic [1:0]            mode_sh;
  logic [3*DATA_W-1:0]   solid_sh;

  logic                  hs_act, vs_act, h_act, v_act, de_int, frame_c;
  logic [10:0]           xpos_c, ypos_c;
  logic [DATA_W-1:0]     gray;
  logic [3*DATA_W-1:0]   pix;

  function automatic logic [3*DATA_W-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = {FULL, FULL, FULL};
      3'd1:    bar_color = {FULL, FULL, NONE};
      3'd2:    bar_color = {NONE, FULL, FULL};
      3'd3:    bar_color = {NONE, FULL, NONE};
      3'd4:    bar_color = {FULL, NONE, FULL};
      3'd5:    bar_color = {FULL, NONE, NONE};
      3'd6:    bar_color = {NONE, NONE, FULL};
      default: bar_color = {NONE, NONE, NONE};
    endcase
  endfunction

  // Region decode of the current counter state
  always_comb begin
    hs_act  = (h_cnt < H_SYNC_C);
    vs_act  = (v_cnt < V_SYNC_C);
    h_act   = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
    v_act   = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
    de_int  = h_act && v_act;
    frame_c = (h_cnt == {HW{1'b0}}) && (v_cnt == {VW{1'b0}});
    if (de_int) begin
      xpos_c = 11'(h_cnt - H_START_C);
      ypos_c = 11'(v_cnt - V_START_C);
    end else begin
      xpos_c = 11'd0;
      ypos_c = 11'd0;
    end
  end

  // Pattern selection from the frame-stable shadow mode
  always_comb begin
    gray = DATA_W'(xpos_c);
    pix  = {3*DATA_W{1'b0}};
    if (de_int) begin
      case (mode_sh)
        2'd0:    pix = bar_color(bar_idx[2:0]);
        2'd1:    pix = (xpos_c[CHK_SHIFT] ^ ypos_c[CHK_SHIFT]) ? {3*DATA_W{1'b1}} : {3*DATA_W{1'b0}};
        2'd2:    pix = {gray, gray, gray};
        2'd3:    pix = solid_sh;
        default: pix = {3*DATA_W{1'b0}};
      endcase
    end else begin
      pix = {3*DATA_W{1'b0}};
    end
  end

  // Counters, bar tracking, shadow capture and output registers; everything freezes while en=0
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      h_cnt       <= {HW{1'b0}};
      v_cnt       <= {VW{1'b0}};
      bar_sub     <= {SW{1'b0}};
      bar_idx     <= {IDX_W{1'b0}};
      mode_sh     <= 2'd0;
      solid_sh    <= {3*DATA_W{1'b0}};
      lcd_de      <= 1'b0;
      lcd_hs      <= ~HS_POL;
      lcd_vs      <= ~VS_POL;
      lcd_rgb     <= {3*DATA_W{1'b0}};
      pixel_xpos  <= 11'd0;
      pixel_ypos  <= 11'd0;
      frame_start <= 1'b0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= {HW{1'b0}};
        v_cnt <= (v_cnt == V_LAST) ? {VW{1'b0}} : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      // Bar registers describe the pixel at h_cnt, so clear them one step ahead of the first active pixel
      if (h_cnt == H_PRE_C) begin
        bar_sub <= {SW{1'b0}};
        bar_idx <= {IDX_W{1'b0}};
      end else if (h_act) begin
        if (bar_sub == BAR_LAST) begin
          bar_sub <= {SW{1'b0}};
          bar_idx <= bar_idx + IDX_W'(1);
        end else begin
          bar_sub <= bar_sub + SW'(1);
        end
      end
      if (frame_c) begin
        mode_sh  <= mode;
        solid_sh <= solid_rgb;
      end
      lcd_de      <= de_int;
      lcd_hs      <= hs_act ? HS_POL : ~HS_POL;
      lcd_vs      <= vs_act ? VS_POL : ~VS_POL;
      lcd_rgb     <= pix;
      pixel_xpos  <= xpos_c;
      pixel_ypos  <= ypos_c;
      frame_start <= frame_c;
    end
  end

endmodule

// File: tb/tb_lcd_pattern_timing.sv
// Scoreboard bench for lcd_pattern_timing on a small 14x7 raster with 4 bars.
module tb_lcd_pattern_timing;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic        lcd_de, lcd_hs, lcd_vs, frame_start;
  logic [23:0] lcd_rgb;
  logic [10:0] pixel_xpos, pixel_ypos;

  lcd_pattern_timing #(
    .H_SYNC(2), .H_BP(2), .H_DISP(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_DISP(4), .V_FP(1),
    .DATA_W(8), .NUM_BARS(4), .CHK_SHIFT(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .lcd_pclk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .lcd_de(lcd_de), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_rgb(lcd_rgb),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // {de, hs, vs, frame_start, rgb, xpos, ypos}
  logic [49:0] obs;
  assign obs = {lcd_de, lcd_hs, lcd_vs, frame_start, lcd_rgb, pixel_xpos, pixel_ypos};
  localparam logic [49:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 11'h0, 11'h0};

  int passed = 0;
  int total  = 0;
  logic [49:0] sb_q[$];
  logic [49:0] exp_v;

  int          m_h, m_v;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;
  logic [49:0] m_out;

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx % 8)
      0: bar_rgb = 24'hFFFFFF;
      1: bar_rgb = 24'hFFFF00;
      2: bar_rgb = 24'h00FFFF;
      3: bar_rgb = 24'h00FF00;
      4: bar_rgb = 24'hFF00FF;
      5: bar_rgb = 24'hFF0000;
      6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  function automatic logic [49:0] model_out();
    logic de, hs, vs, fs;
    logic [23:0] rgb;
    int x, y;
    de = (m_h >= 4) && (m_h < 12) && (m_v >= 2) && (m_v < 6);
    hs = !(m_h < 2);
    vs = !(m_v < 1);
    fs = (m_h == 0) && (m_v == 0);
    x = de ? m_h - 4 : 0;
    y = de ? m_v - 2 : 0;
    rgb = 24'h0;
    if (de) begin
      case (m_mode)
        2'd0: rgb = bar_rgb(x / 2);
        2'd1: rgb = ((((x >> 1) ^ (y >> 1)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
        2'd2: rgb = {3{x[7:0]}};
        default: rgb = m_solid;
      endcase
    end
    model_out = {de, hs, vs, fs, rgb, 11'(x), 11'(y)};
  endfunction

  // Drive one cycle of inputs and push the model's expectation for the resulting outputs
  task automatic drive(input logic r, input logic e, input logic [1:0] md, input logic [23:0] sd);
    rst = r; en = e; mode = md; solid_rgb = sd;
    @(posedge clk);
    if (r) begin
      m_h = 0; m_v = 0; m_mode = 2'd0; m_solid = 24'h0; m_out = RST_VEC;
    end else if (e) begin
      m_out = model_out();
      if (m_h == 0 && m_v == 0) begin
        m_mode = md; m_solid = sd;
      end
      if (m_h == 13) begin
        m_h = 0;
        m_v = (m_v == 6) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    sb_q.push_back(m_out);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] md);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, md, 24'h0);
    sb_q.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd3, 24'hABCDEF);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL reset_sb got=%h exp=%h", obs, exp_v);
      else passed++;
      total++;
      if (obs !== RST_VEC) $display("FAIL reset_values got=%h exp=%h", obs, RST_VEC);
      else passed++;
    end
  endtask

  task automatic test_timing();
    int fs_n = 0, hs_n = 0, vs_n = 0, de_n = 0, fs_first = -1, fs_second = -1;
    do_reset(2'd0);
    for (int i = 0; i < 196; i++) begin
      drive(1'b0, 1'b1, 2'd0, 24'h0);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL timing_sb i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (frame_start) begin
        fs_n++;
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (lcd_hs == 1'b0) hs_n++;
      if (lcd_vs == 1'b0) vs_n++;
      if (lcd_de) de_n++;
    end
    total++;
    if (fs_n != 2 || fs_first != 0) $display("FAIL frame_start_count got=%0d first=%0d exp=2 first=0", fs_n, fs_first);
    else passed++;
    total++;
    if (fs_second - fs_first != 98) $display("FAIL frame_period got=%0d exp=98", fs_second - fs_first);
    else passed++;
    total++;
    if (hs_n != 28) $display("FAIL hsync_active got=%0d exp=28", hs_n);
    else passed++;
    total++;
    if (vs_n != 28) $display("FAIL vsync_active got=%0d exp=28", vs_n);
    else passed++;
    total++;
    if (de_n != 64) $display("FAIL de_count got=%0d exp=64", de_n);
    else passed++;
  endtask

  task automatic test_colorbar();
    logic [23:0] exp_bar[8] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                                24'h00FFFF, 24'h00FFFF, 24'h00FF00, 24'h00FF00};
    logic [23:0] got[8];
    int n = 0;
    do_reset(2'd0);
    for (int i = 0; i < 200 && n < 8; i++) begin
      drive(1'b0, 1'b1, 2'd0, 24'h0);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL colorbar_sb i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (lcd_de && pixel_ypos == 11'd0 && pixel_xpos < 11'd8) begin
        got[pixel_xpos[2:0]] = lcd_rgb;
        n++;
      end
    end
    total++;
    if (n != 8) $display("FAIL colorbar_timeout got=%0d pixels exp=8", n);
    else passed++;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (got[k] !== exp_bar[k]) $display("FAIL colorbar_x%0d got=%h exp=%h", k, got[k], exp_bar[k]);
      else passed++;
    end
  endtask

  task automatic test_mode_change();
    int cnt_a = 0, cnt_b = 0;
    do_reset(2'd0);
    for (int i = 0; i < 196; i++) begin
      drive(1'b0, 1'b1, (i >= 40) ? 2'd3 : 2'd0, (i >= 40) ? 24'h123456 : 24'h0);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL modechg_sb i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (lcd_de && lcd_rgb == 24'h123456) begin
        if (i < 98) cnt_a++;
        else cnt_b++;
      end
    end
    total++;
    if (cnt_a != 0) $display("FAIL modechg_same_frame got=%0d exp=0", cnt_a);
    else passed++;
    total++;
    if (cnt_b != 32) $display("FAIL modechg_next_frame got=%0d exp=32", cnt_b);
    else passed++;
  endtask

  task automatic test_checker_ramp();
    logic [23:0] exp_chk[8] = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF,
                                24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
    logic [23:0] got[8];
    int n = 0;
    logic found = 1'b0;
    do_reset(2'd1);
    for (int i = 0; i < 200 && n < 8; i++) begin
      drive(1'b0, 1'b1, 2'd1, 24'h0);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL checker_sb i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (lcd_de && pixel_ypos == 11'd0 && pixel_xpos < 11'd8) begin
        got[pixel_xpos[2:0]] = lcd_rgb;
        n++;
      end
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (n != 8 || got[k] !== exp_chk[k]) $display("FAIL checker_x%0d got=%h exp=%h n=%0d", k, got[k], exp_chk[k], n);
      else passed++;
    end
    do_reset(2'd2);
    for (int i = 0; i < 200 && !found; i++) begin
      drive(1'b0, 1'b1, 2'd2, 24'h0);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL ramp_sb i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (lcd_de && pixel_xpos == 11'd5) begin
        found = 1'b1;
        total++;
        if (lcd_rgb !== 24'h050505) $display("FAIL ramp_x5 got=%h exp=050505", lcd_rgb);
        else passed++;
      end
    end
    total++;
    if (!found) $display("FAIL ramp_timeout got=none exp=xpos5");
    else passed++;
  endtask

  task automatic test_stall_reset();
    logic [49:0] held;
    do_reset(2'd0);
    for (int i = 0; i < 60; i++) begin
      if (i >= 35 && i < 40) drive(1'b0, 1'b0, 2'd0, 24'h0);
      else drive(1'b0, 1'b1, 2'd0, 24'h0);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL stall_sb i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (i == 34) held = obs;
      if (i >= 35 && i < 40) begin
        total++;
        if (obs !== held) $display("FAIL stall_frozen i=%0d got=%h exp=%h", i, obs, held);
        else passed++;
      end
    end
    drive(1'b1, 1'b0, 2'd0, 24'h0);
    exp_v = sb_q.pop_front();
    total++;
    if (obs !== RST_VEC) $display("FAIL midframe_reset got=%h exp=%h", obs, RST_VEC);
    else passed++;
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b1, 2'd0, 24'h0);
      exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) $display("FAIL post_reset_sb i=%0d got=%h exp=%h", i, obs, exp_v);
      else passed++;
      if (i == 0) begin
        total++;
        if (frame_start !== 1'b1) $display("FAIL post_reset_frame_start got=%b exp=1", frame_start);
        else passed++;
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_timing();
    test_colorbar();
    test_mode_change();
    test_checker_ramp();
    test_stall_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
